wb_arbiter_2m: RTL and testbench

Two-master Wishbone B3 arbiter that shares one slave port, typically the boot ROM or a RAM block, between an instruction-fetch master and a data master. Arbitration is round-robin with grant lock for the full `cyc` of the owning master, so bursts are never split. A per-access watchdog terminates stalled slave cycles with an error. It sits between the CPU bus masters and a single memory slave.

---
 rtl/wb_arbiter_2m.sv | 166 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B3 arbiter onto a single slave port. Round-robin grant held for the
// owner's whole cyc, with a per-access watchdog that terminates stalled cycles with an error.
module wb_arbiter_2m #(
    parameter int unsigned data_width = 32,
    parameter int unsigned addr_width = 32,
    parameter int unsigned timeout    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [data_width-1:0] m0_dat_i,
    output logic [data_width-1:0] m0_dat_o,
    input  logic [addr_width-1:0] m0_adr_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [2:0]            m0_cti_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic [data_width-1:0] m1_dat_i,
    output logic [data_width-1:0] m1_dat_o,
    input  logic [addr_width-1:0] m1_adr_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [2:0]            m1_cti_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic [data_width-1:0] s_dat_o,
    output logic [addr_width-1:0] s_adr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic [2:0]            s_cti_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [data_width-1:0] s_dat_i,
    input  logic                  s_ack_i
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [7:0] WdLimit = 8'(timeout - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       err_q, err_d;
    logic       stb_sel;
    logic       stall;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d != state_q) begin
            if (state_d == StGnt0) begin
                last_d = 1'b0;
            end else if (state_d == StGnt1) begin
                last_d = 1'b1;
            end
        end
    end

    // Output logic: slave-side mux and master-side gating
    always_comb begin
        s_dat_o = m0_dat_i;
        s_adr_o = m0_adr_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_cti_o = 3'b000;
        s_cyc_o = 1'b0;
        stb_sel = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s_cti_o = m0_cti_i;
                s_cyc_o = m0_cyc_i;
                stb_sel = m0_stb_i;
            end
            StGnt1: begin
                s_dat_o = m1_dat_i;
                s_adr_o = m1_adr_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_cti_o = m1_cti_i;
                s_cyc_o = m1_cyc_i;
                stb_sel = m1_stb_i;
            end
            default: ;
        endcase
        // The error cycle terminates the access, so the slave must not see a strobe then.
        s_stb_o  = stb_sel & ~err_q;
        m0_ack_o = s_ack_i & (state_q == StGnt0) & ~err_q;
        m1_ack_o = s_ack_i & (state_q == StGnt1) & ~err_q;
        m0_err_o = err_q & (state_q == StGnt0);
        m1_err_o = err_q & (state_q == StGnt1);
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Watchdog: a grant change or an owner dropping cyc pre-empts a pending error.
    assign stall = s_stb_o & ~s_ack_i & (state_d == state_q);

    always_comb begin
        wd_cnt_d = 8'd0;
        err_d    = 1'b0;
        if (stall) begin
            if (wd_cnt_q == WdLimit) begin
                err_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus random traffic, every cycle checked against
// a transaction-level ownership/watchdog model.
module tb_wb_arbiter_2m;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat;
    logic [AW-1:0] m0_adr, m1_adr, s_adr_o;
    logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic [3:0]    m0_sel, m1_sel, s_sel_o;
    logic [2:0]    m0_cti, m1_cti, s_cti_o;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack;

    wb_arbiter_2m #(.data_width(DW), .addr_width(AW), .timeout(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_adr_i(m0_adr), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_adr_i(m1_adr), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = nobody), previous owner, stalled-strobe run length, error flag.
    int own;
    int last_m;
    int stall;
    bit merr;
    int n_own, n_last, n_stall;
    bit n_err;
    int len[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cyc_of(int n);
        return (n == 0) ? m0_cyc : m1_cyc;
    endfunction

    function automatic logic stb_of(int n);
        return (n == 0) ? m0_stb : m1_stb;
    endfunction

    function automatic logic exp_stb();
        return (own >= 0) ? (stb_of(own) & ~merr) : 1'b0;
    endfunction

    task automatic model_reset();
        own = -1; last_m = 1; stall = 0; merr = 0;
    endtask

    task automatic compare();
        logic e_cyc;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic e_we;
        logic [3:0] e_sel;
        logic [2:0] e_cti;
        e_cyc = (own >= 0) ? cyc_of(own) : 1'b0;
        e_adr = (own == 1) ? m1_adr : m0_adr;
        e_dat = (own == 1) ? m1_dat : m0_dat;
        e_we  = (own == 1) ? m1_we : m0_we;
        e_sel = (own == 1) ? m1_sel : m0_sel;
        e_cti = (own < 0) ? 3'b000 : ((own == 0) ? m0_cti : m1_cti);
        chk("s_cyc_o", 64'(s_cyc_o), 64'(e_cyc));
        chk("s_stb_o", 64'(s_stb_o), 64'(exp_stb()));
        chk("s_cti_o", 64'(s_cti_o), 64'(e_cti));
        chk("s_adr_o", 64'(s_adr_o), 64'(e_adr));
        chk("s_dat_o", 64'(s_dat_o), 64'(e_dat));
        chk("s_we_o", 64'(s_we_o), 64'(e_we));
        chk("s_sel_o", 64'(s_sel_o), 64'(e_sel));
        chk("m0_ack_o", 64'(m0_ack_o), 64'(s_ack && own == 0 && !merr));
        chk("m1_ack_o", 64'(m1_ack_o), 64'(s_ack && own == 1 && !merr));
        chk("m0_err_o", 64'(m0_err_o), 64'(merr && own == 0));
        chk("m1_err_o", 64'(m1_err_o), 64'(merr && own == 1));
        chk("m0_dat_o", 64'(m0_dat_o), 64'(s_dat));
        chk("m1_dat_o", 64'(m1_dat_o), 64'(s_dat));
    endtask

    task automatic settle();
        #1;
        compare();
    endtask

    // Apply one clock edge to both DUT and model; inputs are held until the next negedge.
    task automatic tick();
        n_own = own;
        n_err = 0;
        n_stall = 0;
        if (own < 0) begin
            if (m0_cyc && m1_cyc) n_own = (last_m == 1) ? 0 : 1;
            else if (m0_cyc) n_own = 0;
            else if (m1_cyc) n_own = 1;
        end else if (!cyc_of(own)) begin
            n_own = cyc_of(1 - own) ? 1 - own : -1;
        end
        if (own >= 0 && n_own == own && exp_stb() && !s_ack) begin
            if (stall + 1 == TO) n_err = 1;
            else n_stall = stall + 1;
        end
        n_last = (n_own >= 0 && n_own != own) ? n_own : last_m;
        @(posedge clk);
        own = n_own; last_m = n_last; stall = n_stall; merr = n_err;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        m0_we = 0; m1_we = 0; m0_sel = 4'hf; m1_sel = 4'hf;
        m0_cti = 3'b000; m1_cti = 3'b000;
        m0_adr = '0; m1_adr = '0; m0_dat = '0; m1_dat = '0;
        s_ack = 0; s_dat = 32'hcafe_0000;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        s_ack = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        settle();
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_ack0", 64'(m0_ack_o), 64'd0);
        @(negedge clk);
        rst = 0;
        s_ack = 0;
    endtask

    task automatic drive_random(input int pct);
        for (int n = 0; n < 2; n++)
            if (len[n] == 0 && $urandom_range(0, 3) == 0) len[n] = $urandom_range(1, 30);
        m0_cyc = (len[0] > 0); m1_cyc = (len[1] > 0);
        m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
        m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
        m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
        m0_we = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
        m0_sel = 4'($urandom); m1_sel = 4'($urandom);
        m0_cti = 3'($urandom); m1_cti = 3'($urandom);
        s_dat = $urandom;
        s_ack = ($urandom_range(0, 99) < pct);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n0, n1, rise, errc;
        logic exp_c[6];
        logic [31:0] exp_a[6];
        logic d0, d1, nd0, nd1;
        int pcts[4];

        do_reset();

        // Single read from m0: one-cycle arbitration latency, same-cycle ack.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; m0_cti = 3'b000;
        settle(); chk("t1_stb_latency", 64'(s_stb_o), 64'd0); tick();
        s_ack = 1;
        settle();
        chk("t1_stb_up", 64'(s_stb_o), 64'd1);
        chk("t1_ack0", 64'(m0_ack_o), 64'd1);
        chk("t1_ack1", 64'(m1_ack_o), 64'd0);
        tick();
        idle_inputs(); settle(); tick();

        // Tie with repeating single reads: GNT0, gap, GNT1, gap, GNT0.
        do_reset();
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_a = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h100};
        m0_adr = 32'h100; m1_adr = 32'h200; s_ack = 1;
        d0 = 0; d1 = 0;
        for (int k = 0; k < 6; k++) begin
            m0_cyc = ~d0; m0_stb = ~d0; m1_cyc = ~d1; m1_stb = ~d1;
            settle();
            chk("t2_cyc", 64'(s_cyc_o), 64'(exp_c[k]));
            if (exp_c[k]) chk("t2_owner_adr", 64'(s_adr_o), 64'(exp_a[k]));
            nd0 = m0_ack_o; nd1 = m1_ack_o;
            tick();
            d0 = nd0; d1 = nd1;
        end
        idle_inputs(); settle(); tick();

        // m1 burst with m0 requesting at beat 2: no pre-emption.
        n0 = 0; n1 = 0;
        m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_adr = 32'h300;
        settle(); chk("t3_idle", 64'(s_cyc_o), 64'd0); tick();
        for (int b = 0; b < 4; b++) begin
            m1_cti = (b == 3) ? 3'b111 : 3'b010;
            m1_adr = 32'h300 + 32'(4 * b);
            s_ack = 1;
            if (b == 1) begin m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500; end
            settle();
            n1 += int'(m1_ack_o); n0 += int'(m0_ack_o);
            tick();
        end
        m1_cyc = 0; m1_stb = 0;
        settle(); chk("t3_handoff_gap", 64'(s_cyc_o), 64'd0); n0 += int'(m0_ack_o); tick();
        settle();
        chk("t3_m0_granted", 64'(s_adr_o), 64'h500);
        chk("t3_m0_ack", 64'(m0_ack_o), 64'd1);
        tick();
        chk("t3_m1_acks", 64'(n1), 64'd4);
        chk("t3_m0_early_acks", 64'(n0), 64'd0);
        idle_inputs(); settle(); tick();

        // Watchdog: slave never acks.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        rise = -1; errc = -1;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (rise < 0 && s_stb_o === 1'b1) rise = k;
            if (errc < 0 && m0_err_o === 1'b1) begin
                errc = k;
                chk("t4_stb_in_err", 64'(s_stb_o), 64'd0);
            end
            if (errc >= 0 && k == errc + 1) begin
                chk("t4_err_pulse", 64'(m0_err_o), 64'd0);
                chk("t4_grant_held", 64'(s_cyc_o), 64'd1);
            end
            chk("t4_no_ack", 64'(m0_ack_o), 64'd0);
            tick();
            if (errc >= 0 && k >= errc + 2) break;
        end
        chk("t4_err_seen", 64'(errc >= 0), 64'd1);
        chk("t4_err_delay", 64'(errc - rise), 64'd16);
        idle_inputs(); settle(); tick();

        // Ack (mode 0) or owner drop (mode 1) on the last wait cycle suppresses the error.
        for (int mode = 0; mode < 2; mode++) begin
            m0_cyc = 1; m0_stb = 1;
            settle(); tick();
            for (int j = 0; j < 16; j++) begin
                if (j == 15) begin
                    if (mode == 0) s_ack = 1;
                    else begin m0_cyc = 0; m0_stb = 0; end
                end
                settle(); tick();
            end
            s_ack = 0;
            settle();
            chk("t5_no_err", 64'(m0_err_o), 64'd0);
            chk("t5_cyc", 64'(s_cyc_o), 64'(mode == 0));
            tick();
            idle_inputs(); settle(); tick();
        end

        // Asynchronous reset during m1 burst beat 2, then tie goes to m0.
        m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_adr = 32'h700;
        settle(); tick();
        s_ack = 1; settle(); tick();
        settle();
        chk("t6_beat2_ack", 64'(m1_ack_o), 64'd1);
        #1 rst = 1;
        #1 model_reset();
        compare();
        chk("t6_async_cyc", 64'(s_cyc_o), 64'd0);
        chk("t6_async_ack", 64'(m1_ack_o), 64'd0);
        chk("t6_async_err", 64'(m1_err_o), 64'd0);
        @(negedge clk);
        rst = 0;
        idle_inputs();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h800; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h900;
        settle(); tick();
        settle(); chk("t6_tie_m0", 64'(s_adr_o), 64'h800); tick();
        idle_inputs(); settle(); tick();

        // Random traffic with varying slave responsiveness, including a dead slave.
        pcts = '{0, 30, 80, 100};
        len[0] = 0; len[1] = 0;
        for (int c = 0; c < 2400; c++) begin
            drive_random(pcts[(c / 150) % 4]);
            settle();
            tick();
            for (int n = 0; n < 2; n++) if (len[n] > 0) len[n]--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
